// File: rtl/flag_pkg.sv
// Shared types for the C/Z flag shadow stack.
package flag_pkg;

    localparam int unsigned FLAG_CTX_W = 2;

    typedef struct packed {
        logic c;
        logic z;
    } flag_ctx_t;

endpackage

// File: rtl/flag_shadow_stack_if.sv
// Control-unit side of the flag shadow stack: live flags, save/restore pulses and flag-register load outputs.
interface flag_shadow_stack_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

    logic               c_in;
    logic               z_in;
    logic               save;
    logic               restore;
    logic               restore_ie;
    logic               c_out;
    logic               z_out;
    logic               flag_ld;
    logic               ie_out;
    logic               ie_ld;
    logic [DEPTH_W-1:0] depth;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               underflow;

    modport master (
        output c_in, z_in, save, restore, restore_ie,
        input  c_out, z_out, flag_ld, ie_out, ie_ld, depth, full, empty, overflow, underflow
    );

    modport slave (
        input  c_in, z_in, save, restore, restore_ie,
        output c_out, z_out, flag_ld, ie_out, ie_ld, depth, full, empty, overflow, underflow
    );

endinterface

// File: rtl/flag_ctx_lifo.sv
// LIFO of {C,Z} contexts; a simultaneous push and pop on a non-empty stack replaces the top entry.
module flag_ctx_lifo
    import flag_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned SP_W  = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  flag_ctx_t       wdata,
    output flag_ctx_t       rdata,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    flag_ctx_t        mem [DEPTH];
    logic [SP_W-1:0]  sp_nxt;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_en;

    assign top_idx = IDX_W'(sp - SP_W'(1));
    assign rdata   = empty ? flag_ctx_t'('0) : mem[top_idx];

    // Pointer/write decode; sp saturates because full/empty gate every move.
    always_comb begin
        sp_nxt = sp;
        wr_en  = 1'b0;
        wr_idx = IDX_W'(sp);
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push && !full) begin
            wr_en  = 1'b1;
            wr_idx = IDX_W'(sp);
            sp_nxt = sp + SP_W'(1);
        end else if (pop && !push && !empty) begin
            sp_nxt = sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            sp    <= sp_nxt;
            full  <= (sp_nxt == SP_W'(DEPTH));
            empty <= (sp_nxt == '0);
            if (wr_en) begin
                mem[wr_idx] <= wdata;
            end
        end
    end

endmodule

// File: rtl/flag_shadow_stack.sv
// Interrupt-context save/restore of C/Z with one-cycle load strobes to the C/Z and I flag registers.
module flag_shadow_stack
    import flag_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    flag_shadow_stack_if.slave   bus
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);

    flag_ctx_t       wdata;
    flag_ctx_t       top_ctx;
    logic [SP_W-1:0] sp;
    logic            full;
    logic            empty;
    logic            pop_ok;

    assign wdata.c = bus.c_in;
    assign wdata.z = bus.z_in;
    assign pop_ok  = bus.restore && !empty;

    flag_ctx_lifo #(
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.save),
        .pop   (bus.restore),
        .wdata (wdata),
        .rdata (top_ctx),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    assign bus.depth = sp;
    assign bus.full  = full;
    assign bus.empty = empty;

    // Strobes, restored data, I policy (save wins) and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.flag_ld   <= 1'b0;
            bus.c_out     <= 1'b0;
            bus.z_out     <= 1'b0;
            bus.ie_ld     <= 1'b0;
            bus.ie_out    <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.flag_ld <= pop_ok;
            if (pop_ok) begin
                bus.c_out <= top_ctx.c;
                bus.z_out <= top_ctx.z;
            end
            bus.ie_ld <= bus.save || bus.restore;
            if (bus.save) begin
                bus.ie_out <= 1'b0;
            end else if (bus.restore) begin
                bus.ie_out <= bus.restore_ie;
            end
            if (bus.save && !bus.restore && full) begin
                bus.overflow <= 1'b1;
            end
            if (bus.restore && empty) begin
                bus.underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Directed and random checks of flag_shadow_stack against a queue-based context model.
module tb_flag_shadow_stack;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    flag_shadow_stack_if #(.DEPTH(DEPTH)) bus ();

    flag_shadow_stack #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] ref_q[$];
    logic ref_c, ref_z, ref_ie, ref_ovf, ref_uf, ref_fld, ref_ield;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        ref_c = 0; ref_z = 0; ref_ie = 0;
        ref_ovf = 0; ref_uf = 0; ref_fld = 0; ref_ield = 0;
    endtask

    task automatic check_all(input string ph);
        check({ph, ".flag_ld"},   32'(bus.flag_ld),   32'(ref_fld));
        check({ph, ".ie_ld"},     32'(bus.ie_ld),     32'(ref_ield));
        check({ph, ".c_out"},     32'(bus.c_out),     32'(ref_c));
        check({ph, ".z_out"},     32'(bus.z_out),     32'(ref_z));
        check({ph, ".ie_out"},    32'(bus.ie_out),    32'(ref_ie));
        check({ph, ".depth"},     32'(bus.depth),     32'(ref_q.size()));
        check({ph, ".full"},      32'(bus.full),      32'(ref_q.size() == DEPTH));
        check({ph, ".empty"},     32'(bus.empty),     32'(ref_q.size() == 0));
        check({ph, ".overflow"},  32'(bus.overflow),  32'(ref_ovf));
        check({ph, ".underflow"}, 32'(bus.underflow), 32'(ref_uf));
    endtask

    // Apply one cycle of stimulus, advance the model, then check just after the edge.
    task automatic step(input string ph, input bit s, input bit r, input bit rie, input bit c, input bit z);
        logic [1:0] p;
        bus.save = s; bus.restore = r; bus.restore_ie = rie; bus.c_in = c; bus.z_in = z;
        @(posedge clk);
        ref_fld  = 1'b0;
        ref_ield = s | r;
        if (r) begin
            if (ref_q.size() > 0) begin
                p = ref_q.pop_back();
                ref_fld = 1'b1;
                ref_c = p[1];
                ref_z = p[0];
            end else begin
                ref_uf = 1'b1;
            end
        end
        if (s) begin
            if (ref_q.size() < DEPTH) ref_q.push_back({c, z});
            else ref_ovf = 1'b1;
            ref_ie = 1'b0;
        end else if (r) begin
            ref_ie = rie;
        end
        #1;
        check_all(ph);
        bus.save = 0; bus.restore = 0; bus.restore_ie = 0; bus.c_in = 0; bus.z_in = 0;
    endtask

    initial begin
        bus.save = 0; bus.restore = 0; bus.restore_ie = 0; bus.c_in = 0; bus.z_in = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        step("save1", 1, 0, 0, 1, 0);
        step("rest1", 0, 1, 1, 0, 0);

        step("nest_s", 1, 0, 0, 1, 1);
        step("nest_s", 1, 0, 0, 0, 1);
        step("nest_s", 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("nest_r", 0, 1, 1'($urandom_range(0, 1)), 0, 0);

        for (int i = 0; i < 4; i++) step("fill", 1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step("ovf", 1, 0, 0, 1, 1);
        step("full_swap", 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 1'(i & 1), 0, 0);

        step("unf", 0, 1, 1, 0, 0);
        step("unf", 0, 1, 0, 0, 0);
        step("both_empty", 1, 1, 1, 1, 0);
        step("drain2", 0, 1, 1, 0, 0);

        step("swap_s", 1, 0, 0, 1, 1);
        step("swap", 1, 1, 1, 0, 0);
        step("swap_r", 0, 1, 0, 1, 1);

        // Async reset while restore strobes are high.
        step("ar_s", 1, 0, 0, 1, 0);
        step("ar_r", 0, 1, 1, 0, 0);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'(($urandom % 100) < 45), 1'(($urandom % 100) < 40),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flag_shadow_stack.md
# flag_shadow_stack

Interrupt-context save/restore for the C and Z flags, the read-out end of the flag registers. On interrupt acceptance it pushes the live {C,Z} pair and disables interrupts. On RETIE/RETID it pops the pair and drives one-cycle load strobes back into the C/Z flag registers and the I flag. It sits between the control unit's interrupt/return decode and the flag registers' load inputs, and supports nested interrupts up to DEPTH.

## Interface
- DEPTH, 4, number of {C,Z} contexts stored (≥2)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- c_in  in  1  live C flag value
- z_in  in  1  live Z flag value
- save  in  1  one-cycle pulse: interrupt accepted, push context
- restore  in  1  one-cycle pulse: RETIE/RETID executed, pop context
- restore_ie  in  1  I value to apply on restore (1 = RETIE, 0 = RETID)
- c_out  out  1  restored C value, valid while flag_ld=1
- z_out  out  1  restored Z value, valid while flag_ld=1
- flag_ld  out  1  load strobe to C and Z flag registers (wr_en)
- ie_out  out  1  I value to load, valid while ie_ld=1
- ie_ld  out  1  load strobe to I flag register
- depth  out  $clog2(DEPTH+1)  number of stored contexts
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- overflow  out  1  sticky: save attempted while full
- underflow  out  1  sticky: restore attempted while empty

## Operation
- Storage: DEPTH entries of {c,z}, LIFO, indexed by stack pointer sp (= depth).
- save only, not full: write {c_in,z_in} at entry sp, sp+1. Next cycle: ie_ld=1, ie_out=0. flag_ld stays 0.
- save only, full: no write, sp unchanged, overflow←1. ie_ld=1, ie_out=0 still issued, because interrupts are disabled regardless.
- restore only, not empty: read entry sp−1, sp−1. Next cycle: flag_ld=1, c_out/z_out = popped pair, ie_ld=1, ie_out=restore_ie.
- restore only, empty: sp unchanged, underflow←1, flag_ld=0. ie_ld=1 with ie_out=restore_ie is still issued.
- save and restore in the same cycle, not empty: pop then push.
  - The top entry is overwritten with {c_in,z_in` and sp is unchanged.
  - Next cycle: flag_ld=1 with the old top values, ie_ld=1, ie_out=0 (save wins for I).
- save and restore in the same cycle, empty: behaves as save only, and underflow←1.
- overflow/underflow: cleared only by reset.
- Neither strobe asserted: flag_ld=0, ie_ld=0; c_out, z_out and ie_out hold their last values.

## Timing
- All outputs are registered.
- Latency: save/restore at edge N produces strobes high for exactly the cycle following edge N, i.e. one cycle.
- depth, full, empty and the sticky flags update at the same edge as sp.
- Back-to-back pulses on consecutive cycles are each honoured; the strobes are then high on consecutive cycles with per-cycle data.
- Reset values:
  - sp=0, depth=0, empty=1, full=0.
  - flag_ld=0, ie_ld=0, c_out=0, z_out=0, ie_out=0.
  - overflow=0, underflow=0, storage cleared to 0.
- Reset asserted mid-operation, including the cycle of a pending strobe: outputs go to reset values immediately and the pending strobe is dropped.
- Pointer arithmetic never wraps: sp is saturated at 0 and DEPTH by the full/empty rules above.

## Structure
- Shared package flag_pkg:
  - typedef flag_ctx_t packed struct {logic c; logic z;}
  - localparam FLAG_CTX_W = 2
- Sub-module flag_ctx_lifo (DEPTH, flag_ctx_t): storage array plus sp, push/pop/full/empty, with the pop-then-push rule.
- Top-level flag_shadow_stack: strobe/output registers, I-flag policy and sticky error bits.

## Test plan
- Reset, then save with C=1,Z=0 → next cycle ie_ld=1, ie_out=0, flag_ld=0, depth=1; then restore with restore_ie=1 → next cycle flag_ld=1, c_out=1, z_out=0, ie_out=1, depth=0, empty=1.
- Nested: saves of {1,1},{0,1},{1,0} → depth=3. Three restores → c_out/z_out sequence {1,0},{0,1},{1,1}.
- Fill DEPTH=4, then a 5th save → overflow=1, depth=4, ie_ld pulse. Restores return the first four contexts intact.
- Restore when empty → underflow=1, flag_ld=0, ie_ld=1, ie_out=restore_ie, depth=0.
- Top={1,1}, same-cycle save (C=0,Z=0) and restore → flag_ld=1, c_out=1, z_out=1, ie_out=0, depth unchanged; next restore returns {0,0}.
- Assert reset asynchronously in the cycle after a restore → flag_ld and ie_ld drop to 0 before the next edge; depth=0, overflow=underflow=0.
